// File: rtl/uart_rx_if.sv
// Serial-side and byte-side signals of the UART receiver.
// The receiver uses the slave modport; the line/tick driver and byte consumer use master.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 BCLK;
  logic                 RX;
  logic [DATA_BITS-1:0] DATA;
  logic                 VALID;
  logic                 FRAME_ERR;
  logic                 BUSY;

  modport master (
    output BCLK, RX,
    input  DATA, VALID, FRAME_ERR, BUSY
  );

  modport slave (
    input  BCLK, RX,
    output DATA, VALID, FRAME_ERR, BUSY
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, mid-bit sampling on an oversampling tick,
// single-cycle VALID / FRAME_ERR strobes.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int BAUDCLOCK   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(BAUDCLOCK);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUDCLOCK / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUDCLOCK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic [CW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   busy_q;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rxs;

  // Synchroniser presets to idle-high so reset never looks like a start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rx_sync <= '1;
    else     rx_sync <= {rx_sync[SYNC_STAGES-2:0], bus.RX};
  end

  assign rxs = rx_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (bus.BCLK) begin
        unique case (state)
          S_IDLE: begin
            if (!rxs) begin
              state    <= S_START;
              tick_cnt <= '0;
              busy_q   <= 1'b1;
            end
          end
          S_START: begin
            // Half a bit in: a line that bounced back high was only a glitch.
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rxs) begin
                state   <= S_DATA;
                bit_cnt <= '0;
              end else begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rxs, shreg[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == DATA_LAST) state <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              if (rxs) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
                state   <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                ferr_q <= 1'b1;
                state  <= S_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_BREAK: begin
            // A held-low line must go high before another start is accepted.
            if (rxs) begin
              state    <= S_IDLE;
              tick_cnt <= '0;
              busy_q   <= 1'b0;
            end
          end
          default: begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.DATA      = data_q;
  assign bus.VALID     = valid_q;
  assign bus.FRAME_ERR = ferr_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: normal frames, back-to-back frames, start glitch,
// framing error with held-low line, and reset in mid-frame.
module tb_uart_rx;

  localparam int TICK_DIV = 4;

  logic CLK;
  logic RST;
  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .BAUDCLOCK(16), .SYNC_STAGES(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int vcnt = 0, fcnt = 0, wide_cnt = 0, overlap_cnt = 0;
  int cyc = 0;
  logic [7:0] vdata[$];
  int         vtime[$];
  logic prev_v = 1'b0, prev_f = 1'b0;
  int div = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Oversampling tick, one CLK cycle wide every TICK_DIV cycles.
  initial bus.BCLK = 1'b0;
  always @(negedge CLK) begin
    div = (div == TICK_DIV - 1) ? 0 : div + 1;
    bus.BCLK = (div == 0);
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.VALID && bus.FRAME_ERR) overlap_cnt++;
      if (bus.VALID && prev_v) wide_cnt++;
      if (bus.FRAME_ERR && prev_f) wide_cnt++;
      if (bus.VALID) begin
        vcnt++;
        vdata.push_back(bus.DATA);
        vtime.push_back(cyc);
      end
      if (bus.FRAME_ERR) fcnt++;
    end
    prev_v = bus.VALID;
    prev_f = bus.FRAME_ERR;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge CLK);
      while (!bus.BCLK) @(posedge CLK);
    end
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    bus.RX = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      wait_ticks(16);
    end
    bus.RX = stop;
    wait_ticks(16);
  endtask

  int busy_ticks;

  initial begin
    RST    = 1'b1;
    bus.RX = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_data",  bus.DATA,      32'h0);
    check("rst_valid", bus.VALID,     32'h0);
    check("rst_ferr",  bus.FRAME_ERR, 32'h0);
    check("rst_busy",  bus.BUSY,      32'h0);
    @(negedge CLK);
    RST = 1'b0;
    wait_ticks(4);

    // Single frame 0x55
    send(8'h55, 1'b1);
    check("f55_vcnt", vcnt, 1);
    check("f55_data", bus.DATA, 32'h55);
    check("f55_ferr", fcnt, 0);
    check("f55_busy", bus.BUSY, 32'h0);

    // Back-to-back 0xA5, 0x3C
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    check("b2b_vcnt", vcnt, 3);
    check("b2b_d0", (vcnt >= 2) ? vdata[1] : 8'hxx, 32'hA5);
    check("b2b_d1", (vcnt >= 3) ? vdata[2] : 8'hxx, 32'h3C);
    check("b2b_gap", (vcnt >= 3) ? (vtime[2] - vtime[1]) : 0, 160 * TICK_DIV);

    // Start glitch of 3 ticks
    busy_ticks = 0;
    bus.RX = 1'b0;
    for (int i = 0; i < 24; i++) begin
      wait_ticks(1);
      if (bus.BUSY) busy_ticks++;
      if (i == 2) bus.RX = 1'b1;
    end
    check("glitch_busy_ticks", busy_ticks, 8);
    check("glitch_vcnt", vcnt, 3);
    check("glitch_fcnt", fcnt, 0);
    check("glitch_busy", bus.BUSY, 32'h0);

    // Framing error, line held low for two more bit periods
    send(8'h00, 1'b0);
    wait_ticks(32);
    check("ferr_fcnt", fcnt, 1);
    check("ferr_vcnt", vcnt, 3);
    check("ferr_data", bus.DATA, 32'h3C);
    check("ferr_break_busy", bus.BUSY, 32'h1);
    bus.RX = 1'b1;
    wait_ticks(4);
    check("ferr_release_busy", bus.BUSY, 32'h0);
    send(8'h81, 1'b1);
    check("f81_vcnt", vcnt, 4);
    check("f81_data", bus.DATA, 32'h81);

    // Reset in the middle of data bit 4 of 0xF0
    bus.RX = 1'b0;
    wait_ticks(16 + 4 * 16);
    bus.RX = 1'b1;
    wait_ticks(8);
    check("mid_busy_before", bus.BUSY, 32'h1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("mid_rst_busy",  bus.BUSY,      32'h0);
    check("mid_rst_data",  bus.DATA,      32'h0);
    check("mid_rst_valid", bus.VALID,     32'h0);
    check("mid_rst_ferr",  bus.FRAME_ERR, 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    wait_ticks(40);
    check("mid_vcnt", vcnt, 4);
    check("mid_fcnt", fcnt, 1);
    send(8'h12, 1'b1);
    check("f12_vcnt", vcnt, 5);
    check("f12_data", bus.DATA, 32'h12);

    // Strobe shape over the whole run
    check("strobe_wide", wide_cnt, 0);
    check("strobe_overlap", overlap_cnt, 0);
    check("first_data", (vcnt >= 1) ? vdata[0] : 8'hxx, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
